// File: rtl/compare_job_sequencer_if.sv
// Job/result bus for compare_job_sequencer: job input, comparator side-channel,
// result output and counter status.
interface compare_job_sequencer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_A;
    logic [7:0]       in_B;
    logic [1:0]       in_select;

    logic [7:0]       cmp_A;
    logic [7:0]       cmp_B;
    logic [1:0]       cmp_select;
    logic [15:0]      cmp_Y;

    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_Y;
    logic [1:0]       out_select;

    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] nz_count;
    logic             clear_count;

    // Sequencer side
    modport slave (
        input  in_valid, in_A, in_B, in_select, cmp_Y, out_ready, clear_count,
        output in_ready, cmp_A, cmp_B, cmp_select, out_valid, out_Y, out_select,
               level, nz_count
    );

    // Producer / consumer / comparator side
    modport master (
        output in_valid, in_A, in_B, in_select, cmp_Y, out_ready, clear_count,
        input  in_ready, cmp_A, cmp_B, cmp_select, out_valid, out_Y, out_select,
               level, nz_count
    );
endinterface

// File: rtl/compare_job_sequencer.sv
// Job FIFO feeding an external comparator, with a registered result stage and a
// saturating count of delivered nonzero results.
module compare_job_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    compare_job_sequencer_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
    } job_t;

    job_t             mem_q [DEPTH];
    job_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_y_q, out_y_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic [CNT_W-1:0] nz_q, nz_d;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             out_hs;
    job_t             head;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LVL_W'(DEPTH));
    assign push   = bus.in_valid && !full;
    assign pop    = !empty && (!out_valid_q || bus.out_ready);
    assign out_hs = out_valid_q && bus.out_ready;
    assign head   = mem_q[rd_ptr_q];

    // Head presented to the comparator; zero while the FIFO is empty
    assign bus.cmp_A      = empty ? 8'h00 : head.a;
    assign bus.cmp_B      = empty ? 8'h00 : head.b;
    assign bus.cmp_select = empty ? 2'b00 : head.sel;

    assign bus.in_ready   = !full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_Y      = out_y_q;
    assign bus.out_select = out_sel_q;
    assign bus.level      = level_q;
    assign bus.nz_count   = nz_q;

    // Next-state for FIFO storage, pointers, occupancy, result stage and counter
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_sel_d   = out_sel_q;
        nz_d        = nz_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{a: bus.in_A, b: bus.in_B, sel: bus.in_select};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            out_y_d     = bus.cmp_Y;
            out_sel_d   = head.sel;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Clear wins over a same-cycle increment
        if (bus.clear_count) begin
            nz_d = '0;
        end else if (out_hs && (out_y_q != 16'h0000) && (nz_q != '1)) begin
            nz_d = nz_q + CNT_W'(1);
        end
    end

    // State registers; reset discards buffered jobs and the pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_sel_q   <= '0;
            nz_q        <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_sel_q   <= out_sel_d;
            nz_q        <= nz_d;
        end
    end
endmodule

// File: tb/tb_compare_job_sequencer.sv
// Self-checking bench for compare_job_sequencer: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_compare_job_sequencer;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int          NZ_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
    } job_t;

    logic clk;
    logic rst_n;

    compare_job_sequencer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    compare_job_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Comparator behaviour standing in for comparator_module
    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
        case (s)
            2'd0:    return 16'(a) - 16'(b);
            2'd1:    return {15'b0, (a > b)};
            2'd2:    return 16'(a) * 16'(b);
            default: return (a != b) ? {14'b0, (a < b), 1'b1} : 16'h0000;
        endcase
    endfunction

    assign bus.cmp_Y = golden(bus.cmp_A, bus.cmp_B, bus.cmp_select);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted-but-undelivered jobs in order; front sits in the
    // result register when m_full is set
    job_t        q[$];
    bit          m_full = 0;
    logic [15:0] m_y    = 16'h0;
    logic [1:0]  m_sel  = 2'b0;
    int          m_nz   = 0;
    int          acc_cnt = 0;
    int          hs_cnt  = 0;
    int          max_lvl = 0;
    int          mu_lvl;
    bit          mu_push, mu_pop, mu_hs;
    job_t        mu_next;
    job_t        mu_in;

    always @(posedge clk) begin
        if (rst_n) begin
            mu_lvl  = q.size() - (m_full ? 1 : 0);
            mu_push = bus.in_valid && (mu_lvl < int'(DEPTH));
            mu_pop  = (mu_lvl > 0) && (!m_full || bus.out_ready);
            mu_hs   = m_full && bus.out_ready;
            if (mu_pop) mu_next = q[m_full ? 1 : 0];
            if (bus.clear_count) m_nz = 0;
            else if (mu_hs && m_y != 16'h0 && m_nz < NZ_MAX) m_nz++;
            if (mu_pop) begin
                m_y   = golden(mu_next.a, mu_next.b, mu_next.sel);
                m_sel = mu_next.sel;
            end
            if (mu_hs) begin
                void'(q.pop_front());
                hs_cnt++;
            end
            if (mu_push) begin
                mu_in.a   = bus.in_A;
                mu_in.b   = bus.in_B;
                mu_in.sel = bus.in_select;
                q.push_back(mu_in);
                acc_cnt++;
            end
            m_full = mu_pop ? 1'b1 : (mu_hs ? 1'b0 : m_full);
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        m_full = 0;
        m_y    = 16'h0;
        m_sel  = 2'b0;
        m_nz   = 0;
    end

    // Per-cycle comparison of every DUT output against the model
    int   cp_lvl;
    job_t cp_head;
    always @(negedge clk) begin
        if (rst_n) begin
            cp_lvl = q.size() - (m_full ? 1 : 0);
            if (cp_lvl > 0) cp_head = q[m_full ? 1 : 0];
            else begin
                cp_head.a = 8'h0; cp_head.b = 8'h0; cp_head.sel = 2'b0;
            end
            if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
            chk("level",      32'(bus.level),      32'(cp_lvl));
            chk("in_ready",   32'(bus.in_ready),   32'(cp_lvl < int'(DEPTH)));
            chk("out_valid",  32'(bus.out_valid),  32'(m_full));
            chk("out_Y",      32'(bus.out_Y),      32'(m_y));
            chk("out_select", 32'(bus.out_select), 32'(m_sel));
            chk("nz_count",   32'(bus.nz_count),   32'(m_nz));
            chk("cmp_A",      32'(bus.cmp_A),      32'(cp_head.a));
            chk("cmp_B",      32'(bus.cmp_B),      32'(cp_head.b));
            chk("cmp_select", 32'(bus.cmp_select), 32'(cp_head.sel));
        end
    end

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_A      = a;
        bus.in_B      = b;
        bus.in_select = s;
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    int base;

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_A        = 8'h0;
        bus.in_B        = 8'h0;
        bus.in_select   = 2'b0;
        bus.out_ready   = 1'b1;
        bus.clear_count = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level",     32'(bus.level),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_nz",        32'(bus.nz_count),  32'd0);
        chk("rst_out_Y",     32'(bus.out_Y),     32'd0);
        chk("rst_cmp_A",     32'(bus.cmp_A),     32'd0);
        rst_n = 1'b1;

        // 1: single job, one-cycle latency
        offer(8'h05, 8'h03, 2'b00);
        idle_in();
        chk("t1_level",     32'(bus.level), 32'd1);
        chk("t1_cmp_A",     32'(bus.cmp_A), 32'h05);
        @(negedge clk);
        chk("t1_out_valid", 32'(bus.out_valid),  32'd1);
        chk("t1_out_Y",     32'(bus.out_Y),      32'h0002);
        chk("t1_out_sel",   32'(bus.out_select), 32'd0);
        @(negedge clk);
        chk("t1_nz",        32'(bus.nz_count),   32'd1);
        chk("t1_drained",   32'(bus.out_valid),  32'd0);

        // 2: equal operands under neq, then unequal
        offer(8'h7F, 8'h7F, 2'b11);
        idle_in();
        @(negedge clk);
        chk("t2_out_Y_eq", 32'(bus.out_Y), 32'h0000);
        @(negedge clk);
        chk("t2_nz_hold",  32'(bus.nz_count), 32'd1);
        offer(8'h10, 8'h20, 2'b11);
        idle_in();
        @(negedge clk);
        chk("t2_out_Y_ne", 32'(bus.out_Y), 32'h0003);
        @(negedge clk);
        chk("t2_nz",       32'(bus.nz_count), 32'd2);

        // 3: fill under backpressure, then drain in order
        base = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = 1'b0;
            offer(8'(8'h30 + i), 8'(8'h01 + i), 2'(i));
        end
        idle_in();
        chk("t3_accepted", 32'(acc_cnt - base), 32'd5);
        chk("t3_level",    32'(bus.level),      32'd4);
        chk("t3_in_ready", 32'(bus.in_ready),   32'd0);
        chk("t3_out_valid",32'(bus.out_valid),  32'd1);
        chk("t3_out_Y",    32'(bus.out_Y),      32'h002F);
        bus.out_ready = 1'b1;
        base = hs_cnt;
        repeat (5) @(negedge clk);
        chk("t3_drain_cnt", 32'(hs_cnt - base), 32'd5);
        chk("t3_empty",     32'(bus.level),     32'd0);

        // 4: streaming, one job per cycle
        max_lvl = 0;
        base    = hs_cnt;
        for (int i = 0; i < 20; i++) begin
            offer(8'($urandom), 8'($urandom), 2'($urandom_range(3)));
        end
        idle_in();
        repeat (2) @(negedge clk);
        chk("t4_results", 32'(hs_cnt - base), 32'd20);
        chk("t4_max_lvl", 32'(max_lvl <= 1),  32'd1);

        // 5: saturation and clear priority
        @(negedge clk);
        bus.clear_count = 1'b1;
        @(negedge clk);
        bus.clear_count = 1'b0;
        chk("t5_cleared", 32'(bus.nz_count), 32'd0);
        for (int i = 0; i < 5; i++) offer(8'h05, 8'h03, 2'b00);
        idle_in();
        repeat (2) @(negedge clk);
        chk("t5_sat", 32'(bus.nz_count), 32'd3);
        offer(8'h09, 8'h01, 2'b00);
        idle_in();
        @(negedge clk);
        chk("t5_pending", 32'(bus.out_valid), 32'd1);
        bus.clear_count = 1'b1;
        @(negedge clk);
        bus.clear_count = 1'b0;
        chk("t5_clear_wins", 32'(bus.nz_count), 32'd0);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = 1'b0;
            offer(8'(8'h40 + i), 8'h02, 2'b00);
        end
        idle_in();
        chk("t6_level_pre", 32'(bus.level),     32'd3);
        chk("t6_valid_pre", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_level",     32'(bus.level),     32'd0);
        chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t6_nz",        32'(bus.nz_count),  32'd0);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        offer(8'h22, 8'h11, 2'b00);
        idle_in();
        @(negedge clk);
        chk("t6_post_valid", 32'(bus.out_valid),  32'd1);
        chk("t6_post_Y",     32'(bus.out_Y),      32'h0011);
        chk("t6_post_sel",   32'(bus.out_select), 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/compare_job_sequencer.md
Name: compare_job_sequencer

Overview:
- Upstream feeder and result capture stage for comparator_module.
- Accepts operand jobs (A, B, select) over a valid/ready input and buffers them in a small FIFO.
- Presents the FIFO head combinationally to comparator_module on cmp_A/cmp_B/cmp_select, samples the returned cmp_Y into an output register, and delivers it over valid/ready output.
- Keeps a saturating count of nonzero results.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_W, 8, width of nonzero-result counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  job offered
in_ready  output  1  FIFO can accept; high when level < DEPTH
in_A  input  8  operand A
in_B  input  8  operand B
in_select  input  2  comparison select, passed through to comparator
cmp_A  output  8  FIFO-head A to comparator_module.A
cmp_B  output  8  FIFO-head B to comparator_module.B
cmp_select  output  2  FIFO-head select to comparator_module.select
cmp_Y  input  16  comparator_module.Y, combinational from cmp_*
out_valid  output  1  result register holds data
out_ready  input  1  downstream accepts
out_Y  output  16  registered cmp_Y
out_select  output  2  select of the job that produced out_Y
level  output  $clog2(DEPTH)+1  current FIFO occupancy
nz_count  output  CNT_W  count of delivered results with out_Y != 0
clear_count  input  1  synchronous clear of nz_count

Behaviour:
- Reset, asynchronous on rst_n low: FIFO empty, level=0, read/write pointers=0, out_valid=0, out_Y=0, out_select=0, nz_count=0.
- cmp_A, cmp_B and cmp_select equal the FIFO head when not empty. When empty they are driven to 0. They never change while the head is not popped.
- Push: in_valid && in_ready at a rising edge writes the entry and increments the write pointer. The pointer wraps mod DEPTH; the extra level bit distinguishes full from empty.
- Pop condition: pop = (level != 0) && (!out_valid || out_ready).
- On pop: out_Y <= cmp_Y, out_select <= head select, out_valid <= 1, read pointer increments.
- If out_ready && out_valid and no pop: out_valid <= 0. out_Y and out_select hold their last value.
- Latency: a job pushed at edge t with the FIFO empty and the output register free appears on out_Y with out_valid=1 after edge t+1. Minimum latency is one cycle after acceptance. Throughput is 1 job/cycle when out_ready is held high.
- Simultaneous push and pop: level unchanged.
- Full (level == DEPTH): in_ready=0. A push and pop in the same cycle is still refused; in_ready is not a function of out_ready.
- Empty with out_valid=1 and out_ready=1: out_valid drops next cycle.
- Backpressure: while out_valid=1 && out_ready=0, out_Y, out_select and out_valid are stable, and the FIFO keeps accepting until full.
- Counter: nz_count increments on each output handshake (out_valid && out_ready) where out_Y != 0. It saturates at 2^CNT_W-1.
- clear_count has priority over increment and forces nz_count to 0 at the next edge.
- Reset mid-operation: all buffered jobs and the pending result are discarded immediately. No output handshake is counted.
- The block adds no combinational path from in_* to out_* or to cmp_*. The only combinational path is cmp_* -> cmp_Y -> output register D input.

Test Plan (bench connects cmp_* to comparator_module):
1. Single job, no backpressure:
   - Stimulus: push A=8'h05, B=8'h03, select=2'b00.
   - Required: one cycle later out_valid=1, out_Y=16'h0002, out_select=0.
   - Required: nz_count=1 after the handshake.
2. Equal operands with select=3 (neq):
   - Stimulus: push A=B=8'h7F, select=2'b11.
   - Required: out_Y=16'h0000, nz_count unchanged.
   - Stimulus: then push A=8'h10, B=8'h20, select=2'b11.
   - Required: out_Y=16'h0003.
3. Fill and backpressure:
   - Stimulus: hold out_ready=0 and push 6 jobs.
   - Required: 5 accepted (1 in the output register + 4 in the FIFO), level=4, in_ready=0.
   - Stimulus: release out_ready.
   - Required: results emerge in push order on consecutive cycles.
4. Streaming:
   - Stimulus: out_ready=1, in_valid=1 for 20 cycles with random operands.
   - Required: 20 results, 1 per cycle, each matching the golden comparator model.
   - Required: level never exceeds 1.
5. Counter saturation and clear:
   - Stimulus: CNT_W=2, deliver 5 nonzero results.
   - Required: nz_count=3.
   - Stimulus: assert clear_count in the same cycle as a nonzero handshake.
   - Required: nz_count=0.
6. Reset mid-stream:
   - Stimulus: with level=3 and out_valid=1, pulse rst_n low between clock edges.
   - Required: out_valid=0, level=0 and in_ready=1 immediately.
   - Required: after release, a new job produces the correct result with the one-cycle latency.
